// File: rtl/truth_table_sweeper_if.sv
// Result stream of the truth-table sweeper: one word per input vector, valid/ready handshake.
// The producer holds index and data stable while valid is high and ready is low.
interface truth_table_sweeper_if #(
   parameter int N_IN  = 6,
   parameter int N_OUT = 1
);
   logic             res_valid;
   logic             res_ready;
   logic [N_IN-1:0]  res_index;
   logic [N_OUT-1:0] res_data;

   modport master (output res_valid, output res_index, output res_data, input res_ready);
   modport slave  (input res_valid, input res_index, input res_data, output res_ready);
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: drives all 2^N_IN vectors, holds each SETTLE cycles, samples N_OUT outputs.
// SETTLE+1 cycles per vector with ready high; a result stalls the sweep until res_ready accepts it.
module truth_table_sweeper #(
   parameter int N_IN   = 6,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   output logic [N_IN-1:0]            stim,
   input  logic [N_OUT-1:0]           dut_out,
   truth_table_sweeper_if.master      res,
   output logic                       busy,
   output logic                       done,
   output logic [N_OUT*(N_IN+1)-1:0]  ones_cnt,
   output logic [31:0]                signature
);
   localparam int              FW          = N_IN + 1;
   localparam int              CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};
   localparam logic [31:0]     CRC_POLY    = 32'h04C11DB7;
   localparam logic [31:0]     CRC_INIT    = 32'hFFFFFFFF;

   typedef enum logic [1:0] {IDLE, DRIVE, RESULT, DONE} state_t;

   state_t                  state;
   logic [N_IN-1:0]         idx;
   logic [CW-1:0]           settle_cnt;
   logic [N_OUT*FW-1:0]     ones_next;

   // Highest output bit enters the CRC first, MSB-first shift, no reflection.
   function automatic logic [31:0] crc_advance(input logic [31:0] crc_in, input logic [N_OUT-1:0] bits);
      logic [31:0] c;
      c = crc_in;
      for (int i = N_OUT - 1; i >= 0; i--) begin
         if (c[31] ^ bits[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
         else                 c = {c[30:0], 1'b0};
      end
      return c;
   endfunction

   always_comb begin
      ones_next = ones_cnt;
      for (int k = 0; k < N_OUT; k++) begin
         ones_next[k*FW +: FW] = ones_cnt[k*FW +: FW] + {{N_IN{1'b0}}, dut_out[k]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         settle_cnt    <= '0;
         stim          <= '0;
         res.res_valid <= 1'b0;
         res.res_index <= '0;
         res.res_data  <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         ones_cnt      <= '0;
         signature     <= CRC_INIT;
      end else if (abort) begin
         // Abort outranks start; partial counts stay visible until the next start.
         if (state != IDLE) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            stim          <= '0;
            res.res_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
         end
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= DRIVE;
                  idx        <= '0;
                  settle_cnt <= '0;
                  stim       <= '0;
                  ones_cnt   <= '0;
                  signature  <= CRC_INIT;
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end
            end
            DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state         <= RESULT;
                  settle_cnt    <= '0;
                  res.res_valid <= 1'b1;
                  res.res_index <= idx;
                  res.res_data  <= dut_out;
                  ones_cnt      <= ones_next;
                  signature     <= crc_advance(signature, dut_out);
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            RESULT: begin
               if (res.res_ready) begin
                  res.res_valid <= 1'b0;
                  if (idx == IDX_LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= DRIVE;
                     idx   <= idx + 1'b1;
                     stim  <= idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (1 and 2 outputs) share control and see combinational DUTs built from stim.
module tb_truth_table_sweeper;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, res_ready, mode;
   logic [5:0]  stim1, stim2;
   logic [0:0]  dut_out1;
   logic [1:0]  dut_out2;
   logic        busy1, done1, busy2, done2;
   logic [6:0]  ones1;
   logic [13:0] ones2;
   logic [31:0] sig1, sig2;

   truth_table_sweeper_if #(.N_IN(6), .N_OUT(1)) rif1();
   truth_table_sweeper_if #(.N_IN(6), .N_OUT(2)) rif2();

   assign rif1.res_ready = res_ready;
   assign rif2.res_ready = res_ready;
   assign dut_out1 = mode ? stim1[0] : 1'b0;
   assign dut_out2 = {stim2[5] & stim2[4], |stim2};

   truth_table_sweeper #(.N_IN(6), .N_OUT(1), .SETTLE(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim1), .dut_out(dut_out1),
      .res(rif1), .busy(busy1), .done(done1), .ones_cnt(ones1), .signature(sig1));

   truth_table_sweeper #(.N_IN(6), .N_OUT(2), .SETTLE(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stim(stim2), .dut_out(dut_out2),
      .res(rif2), .busy(busy2), .done(done2), .ones_cnt(ones2), .signature(sig2));

   int          checks = 0;
   int          failures = 0;
   int          q_idx[$];
   logic        q_dat[$];
   logic [1:0]  dat2_at [64];
   int          done_cyc, hold_good;
   logic [5:0]  st_stim;
   logic [6:0]  st_ones;
   logic [31:0] st_sig, zero_sig;
   logic        st_busy;

   function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
      return (c[31] ^ b) ? ({c[30:0], 1'b0} ^ 32'h04C11DB7) : {c[30:0], 1'b0};
   endfunction

   function automatic int order_errors();
      int bad = 0;
      foreach (q_idx[i]) if (q_idx[i] != i) bad++;
      return bad;
   endfunction

   // Pulses start, then collects every accepted result until done; optionally stalls one index.
   task automatic run_sweep(input int hold_idx, input int hold_len);
      int e, held;
      q_idx.delete(); q_dat.delete();
      hold_good = 0; done_cyc = -1; held = 0;
      @(negedge clk); start = 1'b1; res_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      st_stim = stim1; st_ones = ones1; st_sig = sig1; st_busy = busy1;
      e = 0;
      while (e < 2000) begin
         if (done1) begin done_cyc = e; break; end
         if (hold_idx >= 0 && busy1 && !rif1.res_valid && int'(stim1) == hold_idx) res_ready = 1'b0;
         if (rif1.res_valid && !res_ready && int'(rif1.res_index) == hold_idx) begin
            if (held < hold_len) begin
               held++;
               if (int'(stim1) == hold_idx && rif1.res_data[0] === ((hold_idx % 2) != 0)) hold_good++;
            end else begin
               res_ready = 1'b1;
            end
         end
         if (rif1.res_valid && res_ready) begin
            q_idx.push_back(int'(rif1.res_index));
            q_dat.push_back(rif1.res_data[0]);
         end
         if (rif2.res_valid && res_ready) dat2_at[rif2.res_index] = rif2.res_data;
         @(negedge clk); e++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (stim1 !== 6'd0) begin failures++; $display("FAIL rst_stim: got %0d expected 0", stim1); end
      checks++; if (rif1.res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", rif1.res_valid); end
      checks++; if (rif1.res_index !== 6'd0 || rif1.res_data !== 1'b0) begin failures++; $display("FAIL rst_res: got idx=%0d data=%b expected 0/0", rif1.res_index, rif1.res_data); end
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL rst_flags: got busy=%b done=%b expected 0/0", busy1, done1); end
      checks++; if (ones1 !== 7'd0) begin failures++; $display("FAIL rst_ones: got %0d expected 0", ones1); end
      checks++; if (sig1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL rst_sig: got %h expected ffffffff", sig1); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy1 !== 1'b0 || rif1.res_valid !== 1'b0) begin failures++; $display("FAIL idle_hold: got busy=%b valid=%b expected 0/0", busy1, rif1.res_valid); end
   endtask

   task automatic test_zero_sweep();
      logic [31:0] exp1, exp2;
      mode = 1'b0;
      run_sweep(-1, 0);
      exp1 = 32'hFFFFFFFF; exp2 = 32'hFFFFFFFF;
      for (int i = 0; i < 64; i++) begin
         exp1 = crc_bit(exp1, 1'b0);
         exp2 = crc_bit(exp2, i >= 48);
         exp2 = crc_bit(exp2, i != 0);
      end
      checks++; if (q_idx.size() != 64) begin failures++; $display("FAIL zero_count: got %0d expected 64", q_idx.size()); end
      checks++; if (order_errors() != 0) begin failures++; $display("FAIL zero_order: got %0d out-of-order expected 0", order_errors()); end
      checks++; if (done_cyc != 128) begin failures++; $display("FAIL zero_latency: got %0d expected 128", done_cyc); end
      checks++; if (ones1 !== 7'd0) begin failures++; $display("FAIL zero_ones: got %0d expected 0", ones1); end
      checks++; if (sig1 !== exp1) begin failures++; $display("FAIL zero_sig: got %h expected %h", sig1, exp1); end
      checks++; if (ones2[13:7] !== 7'd16) begin failures++; $display("FAIL two_ones_f1: got %0d expected 16", ones2[13:7]); end
      checks++; if (ones2[6:0] !== 7'd63) begin failures++; $display("FAIL two_ones_f0: got %0d expected 63", ones2[6:0]); end
      checks++; if (dat2_at[0] !== 2'b00 || dat2_at[63] !== 2'b11) begin failures++; $display("FAIL two_data: got %b/%b expected 00/11", dat2_at[0], dat2_at[63]); end
      checks++; if (sig2 !== exp2) begin failures++; $display("FAIL two_sig: got %h expected %h", sig2, exp2); end
      zero_sig = sig1;
      run_sweep(-1, 0);
      checks++; if (sig1 !== zero_sig) begin failures++; $display("FAIL repeat_sig: got %h expected %h", sig1, zero_sig); end
   endtask

   task automatic test_alternate();
      int bad;
      logic [31:0] exp1;
      mode = 1'b1;
      run_sweep(-1, 0);
      bad = 0; exp1 = 32'hFFFFFFFF;
      foreach (q_dat[i]) if (q_dat[i] !== ((i % 2) != 0)) bad++;
      for (int i = 0; i < 64; i++) exp1 = crc_bit(exp1, (i % 2) != 0);
      checks++; if (q_dat.size() != 64 || bad != 0) begin failures++; $display("FAIL alt_data: got %0d results %0d wrong expected 64/0", q_dat.size(), bad); end
      checks++; if (ones1 !== 7'd32) begin failures++; $display("FAIL alt_ones: got %0d expected 32", ones1); end
      checks++; if (sig1 === zero_sig) begin failures++; $display("FAIL alt_sig_differs: got %h expected not %h", sig1, zero_sig); end
      checks++; if (sig1 !== exp1) begin failures++; $display("FAIL alt_sig: got %h expected %h", sig1, exp1); end
   endtask

   task automatic test_backpressure();
      mode = 1'b1;
      run_sweep(10, 5);
      checks++; if (hold_good != 5) begin failures++; $display("FAIL bp_hold: got %0d stable cycles expected 5", hold_good); end
      checks++; if (q_idx.size() != 64 || order_errors() != 0) begin failures++; $display("FAIL bp_order: got %0d results %0d misordered expected 64/0", q_idx.size(), order_errors()); end
      checks++; if (done_cyc != 133) begin failures++; $display("FAIL bp_latency: got %0d expected 133", done_cyc); end
      checks++; if (ones1 !== 7'd32) begin failures++; $display("FAIL bp_ones: got %0d expected 32", ones1); end
   endtask

   task automatic test_abort();
      int e;
      bit found;
      mode = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      found = 0;
      for (e = 0; e < 500 && !found; e++) begin
         if (busy1 && !rif1.res_valid && stim1 == 6'd20) found = 1;
         else @(negedge clk);
      end
      checks++; if (!found) begin failures++; $display("FAIL abort_reach: got no DRIVE at index 20 expected one"); end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || rif1.res_valid !== 1'b0) begin failures++; $display("FAIL abort_flags: got busy=%b done=%b valid=%b expected 0/0/0", busy1, done1, rif1.res_valid); end
      checks++; if (stim1 !== 6'd0) begin failures++; $display("FAIL abort_stim: got %0d expected 0", stim1); end
      checks++; if (ones1 !== 7'd10) begin failures++; $display("FAIL abort_partial: got %0d expected 10", ones1); end
      @(negedge clk);
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b expected 0", busy1); end
      run_sweep(-1, 0);
      checks++; if (st_busy !== 1'b1 || st_stim !== 6'd0) begin failures++; $display("FAIL restart_state: got busy=%b stim=%0d expected 1/0", st_busy, st_stim); end
      checks++; if (st_ones !== 7'd0 || st_sig !== 32'hFFFFFFFF) begin failures++; $display("FAIL restart_clear: got ones=%0d sig=%h expected 0/ffffffff", st_ones, st_sig); end
      checks++; if (q_idx.size() != 64 || order_errors() != 0) begin failures++; $display("FAIL restart_order: got %0d results %0d misordered expected 64/0", q_idx.size(), order_errors()); end
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL abort_wins: got busy=%b done=%b expected 0/0", busy1, done1); end
   endtask

   task automatic test_start_ignored_and_reset();
      int e, emitted;
      bit sent, found;
      mode = 1'b0;
      q_idx.delete();
      @(negedge clk); start = 1'b1; res_ready = 1'b1;
      @(negedge clk); start = 1'b0;
      sent = 0; found = 0;
      for (e = 0; e < 500 && !found; e++) begin
         if (!sent && busy1 && stim1 == 6'd15) begin start = 1'b1; sent = 1; end
         else start = 1'b0;
         if (rif1.res_valid && rif1.res_index == 6'd30) found = 1;
         else begin
            if (rif1.res_valid && res_ready) q_idx.push_back(int'(rif1.res_index));
            @(negedge clk);
         end
      end
      start = 1'b0;
      checks++; if (!found || q_idx.size() != 30 || order_errors() != 0) begin failures++; $display("FAIL start_ignored: got found=%0d %0d results %0d misordered expected 1/30/0", found, q_idx.size(), order_errors()); end
      rst_n = 1'b0;
      #1;
      checks++; if (stim1 !== 6'd0 || rif1.res_valid !== 1'b0 || rif1.res_index !== 6'd0) begin failures++; $display("FAIL midrst_out: got stim=%0d valid=%b idx=%0d expected 0/0/0", stim1, rif1.res_valid, rif1.res_index); end
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || ones1 !== 7'd0 || sig1 !== 32'hFFFFFFFF) begin failures++; $display("FAIL midrst_state: got busy=%b done=%b ones=%0d sig=%h expected 0/0/0/ffffffff", busy1, done1, ones1, sig1); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      emitted = 0;
      repeat (6) begin
         @(negedge clk);
         if (rif1.res_valid || busy1) emitted++;
      end
      checks++; if (emitted != 0) begin failures++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", emitted); end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1; mode = 1'b0;
      test_reset();
      test_zero_sweep();
      test_alternate();
      test_backpressure();
      test_abort();
      test_start_ignored_and_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running expected finished");
      $fatal(1, "time limit");
   end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequential exhaustive-stimulus engine for combinational blocks under test. It sweeps every input combination for N_IN inputs, waits a programmable settle time, and samples N_OUT DUT outputs for each combination. Each sample is streamed out over a valid/ready interface, and the engine accumulates a per-output ones count and a 32-bit CRC signature. It sits between a bench or on-chip controller and any combinational DUT, replacing hand-written for-loop stimulus.

Parameters:
N_IN, 6, number of DUT inputs driven (1..16); sweep length is 2^N_IN vectors
N_OUT, 1, number of DUT outputs sampled (1..32)
SETTLE, 1, cycles each vector is held before sampling (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; accepted only in IDLE or DONE
abort  in  1  terminate sweep; return to IDLE next cycle
stim  out  N_IN  vector driven to DUT; stim[N_IN-1] is the first (MSB) DUT input
dut_out  in  N_OUT  DUT outputs, sampled
res_valid  out  1  result word available
res_ready  in  1  consumer accepts result
res_index  out  N_IN  vector index of the current result
res_data  out  N_OUT  sampled DUT outputs for res_index
busy  out  1  high in DRIVE/RESULT
done  out  1  high in DONE, held until start or abort
ones_cnt  out  N_OUT*(N_IN+1)  per-output count of 1 samples; field k = bits [k*(N_IN+1) +: N_IN+1]
signature  out  32  CRC-32 of all samples

Behaviour:
- Reset values (asynchronous, while rst_n=0): state IDLE; stim=0, res_valid=0, res_index=0, res_data=0, busy=0, done=0, ones_cnt=0, signature=0xFFFFFFFF; settle counter=0.
- States:
  - IDLE: stays until start=1.
  - DRIVE: stim=index; settle counter counts 0..SETTLE-1.
  - RESULT: res_valid=1; waits for res_ready.
  - DONE: stays until start or abort.
- IDLE/DONE + start: index:=0, stim:=0, ones_cnt:=0, signature:=0xFFFFFFFF, done:=0; enter DRIVE.
- DRIVE: on its SETTLE-th cycle, at that clock edge:
  - res_data:=dut_out, res_index:=index;
  - ones_cnt[k]+=dut_out[k];
  - signature advances N_OUT bits, dut_out[N_OUT-1] first, polynomial 0x04C11DB7, MSB-first shift, no reflection, no final XOR;
  - enter RESULT.
- RESULT: res_valid=1; res_data and res_index are stable while res_ready=0.
- RESULT, res_valid&&res_ready:
  - if index==2^N_IN-1, enter DONE;
  - otherwise index+=1, stim updates on the same edge, enter DRIVE.
- Timing: stim changes only on entry to DRIVE. With res_ready tied high, each vector takes exactly SETTLE+1 cycles. The full sweep takes 2^N_IN*(SETTLE+1) cycles from the start edge to DONE.
- Index wrap: the index never exceeds 2^N_IN-1. ones_cnt width N_IN+1 holds the maximum value 2^N_IN without overflow.
- start while busy: ignored.
- abort (any state except IDLE): next state IDLE.
  - res_valid:=0, busy:=0, done:=0, stim:=0.
  - ones_cnt and signature keep their partial values until the next start.
- abort and start in the same cycle: abort wins.
- res_ready while not res_valid: ignored.
- rst_n low mid-sweep: immediate return to reset values; no result is emitted.
- ones_cnt and signature are valid for the full sweep only while done=1.

Test Plan:
- N_IN=6, N_OUT=1, SETTLE=1, dut_out=0, res_ready=1, pulse start -> 64 results with res_index 0..63 in order; done rises 128 cycles after the start edge; ones_cnt=0; signature equals the value of a second identical run.
- Same config, dut_out = stim[0] (DUT = input f) -> res_data alternates 0,1 starting at index 0; ones_cnt=32; signature differs from the tied-zero run.
- N_OUT=2, dut_out={stim[5]&stim[4], |stim} -> ones_cnt fields: field1=16, field0=63; res_data=2'b00 at index 0 and 2'b11 at index 63.
- res_ready low for 5 cycles at index 10 -> res_valid held high; res_index=10 and res_data unchanged; stim stays 10; resumes at index 11 after the handshake; no duplicate or lost index.
- abort asserted at index 20 in DRIVE -> IDLE next cycle; busy=0, done=0, stim=0. A subsequent start restarts at index 0 with ones_cnt cleared.
- start pulsed mid-sweep, and rst_n pulsed low at index 30 -> the start is ignored (sweep continues unchanged); the reset immediately forces all outputs to their reset values.
